// File: rtl/ex_mem_skid_pkg.sv
// ex_mem_skid_pkg: shared state enum, branch funct3 encodings and stage payload for the EX/MEM skid stage.
package ex_mem_skid_pkg;
  localparam int PL_DATA_W = 32;
  localparam int PL_RD_W = 5;
  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef struct packed {
    logic [PL_DATA_W-1:0] result;
    logic [PL_RD_W-1:0]   rd;
    logic                 reg_write;
    logic                 mem_write;
    logic [1:0]           result_src;
    logic [PL_DATA_W-1:0] pc_target;
    logic                 pc_src;
  } payload_t;
endpackage

// File: rtl/ex_branch_cond.sv
// ex_branch_cond: branch condition from subtract flags and funct3.
module ex_branch_cond
  import ex_mem_skid_pkg::*;
(
  input  logic       z,
  input  logic       n,
  input  logic       v,
  input  logic       c,
  input  logic [2:0] funct3,
  output logic       taken
);
  always_comb
    taken = funct3 == F3_BEQ  ? z :
            funct3 == F3_BNE  ? !z :
            funct3 == F3_BLT  ? n ^ v :
            funct3 == F3_BGE  ? !(n ^ v) :
            funct3 == F3_BLTU ? !c :
            funct3 == F3_BGEU ? c : 1'b0;
endmodule

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: EX/MEM pipeline register as a two-entry skid buffer with registered in_ready.
// Branch resolution at capture is enabled by defining EX_MEM_BRANCH_RESOLVE_EN.
module ex_mem_skid
  import ex_mem_skid_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_z,
  input  logic              in_n,
  input  logic              in_v,
  input  logic              in_c,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_write,
  input  logic [1:0]        in_result_src,
  input  logic              in_branch,
  input  logic [2:0]        in_funct3,
  input  logic [DATA_W-1:0] in_pc_target,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_reg_write,
  output logic              out_mem_write,
  output logic [1:0]        out_result_src,
  output logic [DATA_W-1:0] out_pc_target,
  output logic              out_pc_src
);
  state_t state, state_nx;
  payload_t main_q, skid_q, cap;
  logic acc, xfer, taken;
`ifdef EX_MEM_BRANCH_RESOLVE_EN
  logic cond;
  ex_branch_cond u_cond (
    .z(in_z), .n(in_n), .v(in_v), .c(in_c), .funct3(in_funct3), .taken(cond)
  );
  assign taken = in_branch && cond;
`else
  logic unused_branch;
  assign unused_branch = ^{in_branch, in_funct3, in_z, in_n, in_v, in_c};
  assign taken = 1'b0;
`endif
  assign cap = '{result: in_result, rd: in_rd, reg_write: in_reg_write, mem_write: in_mem_write,
                 result_src: in_result_src, pc_target: in_pc_target, pc_src: taken};
  // a flushed cycle never accepts, so the killed input is simply dropped
  assign acc = in_valid && in_ready && !flush;
  assign xfer = out_valid && out_ready;
  assign out_valid = state != EMPTY;
  always_comb begin
    state_nx = state;
    if (flush) state_nx = EMPTY;
    else
      case (state)
        EMPTY:   state_nx = acc ? HALF : EMPTY;
        HALF:    state_nx = (acc && !xfer) ? FULL : (!acc && xfer) ? EMPTY : HALF;
        FULL:    state_nx = xfer ? HALF : FULL;
        default: state_nx = EMPTY;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      state    <= state_nx;
      in_ready <= state_nx != FULL;
      if ((state == EMPTY && acc) || (state == HALF && acc && xfer)) main_q <= cap;
      else if (state == FULL && xfer) main_q <= skid_q;
      if (state == HALF && acc && !xfer) skid_q <= cap;
    end
  assign out_result     = main_q.result;
  assign out_rd         = main_q.rd;
  assign out_reg_write  = main_q.reg_write;
  assign out_mem_write  = main_q.mem_write;
  assign out_result_src = main_q.result_src;
  assign out_pc_target  = main_q.pc_target;
  assign out_pc_src     = main_q.pc_src;
endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid: scoreboard bench for ex_mem_skid; a two-deep FIFO model predicts every output.
module tb_ex_mem_skid;
  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [31:0] pc_target;
    logic        pc_src;
  } exp_t;
`ifdef EX_MEM_BRANCH_RESOLVE_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif
  logic clk = 0, rst = 0;
  logic in_valid = 0, in_ready, in_z = 0, in_n = 0, in_v = 0, in_c = 0;
  logic [31:0] in_result = 0, in_pc_target = 0;
  logic [4:0] in_rd = 0;
  logic in_reg_write = 0, in_mem_write = 0, in_branch = 0, flush = 0;
  logic [1:0] in_result_src = 0;
  logic [2:0] in_funct3 = 0;
  logic out_valid, out_ready = 0, out_reg_write, out_mem_write, out_pc_src;
  logic [31:0] out_result, out_pc_target;
  logic [4:0] out_rd;
  logic [1:0] out_result_src;
  int tests = 0, fails = 0;
  exp_t q[$];

  ex_mem_skid dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_z(in_z), .in_n(in_n), .in_v(in_v), .in_c(in_c), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_write(in_mem_write), .in_result_src(in_result_src),
    .in_branch(in_branch), .in_funct3(in_funct3), .in_pc_target(in_pc_target), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
    .out_result_src(out_result_src), .out_pc_target(out_pc_target), .out_pc_src(out_pc_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic br_taken(input logic [2:0] f3, input logic z, n, v, c);
    case (f3)
      3'b000: return z;
      3'b001: return !z;
      3'b100: return n != v;
      3'b101: return n == v;
      3'b110: return !c;
      3'b111: return c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t cur_exp();
    return '{result: in_result, rd: in_rd, rw: in_reg_write, mw: in_mem_write, rs: in_result_src,
             pc_target: in_pc_target,
             pc_src: BR_EN && in_branch && br_taken(in_funct3, in_z, in_n, in_v, in_c)};
  endfunction

  // input side: record every accepted transfer; a flush empties the model
  always @(negedge clk)
    if (rst) begin
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(cur_exp());
    end

  // output side: every transfer must be the oldest outstanding entry
  always @(negedge clk)
    if (rst && out_valid && out_ready && !flush) begin
      if (q.size() == 0) chk("spurious_out", out_valid, 1'b0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("out_result", out_result, e.result);
        chk("out_ctrl", {out_rd, out_reg_write, out_mem_write, out_result_src, out_pc_src},
            {e.rd, e.rw, e.mw, e.rs, e.pc_src});
        chk("out_pc_target", out_pc_target, e.pc_target);
      end
    end

  // occupancy view: out_valid and in_ready follow the model depth
  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk("out_valid_occ", out_valid, q.size() != 0);
      chk("in_ready_occ", in_ready, q.size() < 2);
      if (q.size() != 0) chk("head_result", out_result, q[0].result);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    in_result = $urandom; in_pc_target = $urandom; in_rd = 5'($urandom);
    in_reg_write = 1'($urandom); in_mem_write = 1'($urandom); in_result_src = 2'($urandom);
    in_branch = 1'($urandom); in_funct3 = 3'($urandom);
    {in_z, in_n, in_v, in_c} = 4'($urandom);
  endtask

  task automatic send(input logic [31:0] r);
    rand_fields();
    in_result = r; in_valid = 1;
    step();
    in_valid = 0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1;
    chk("in_ready_before_edge", in_ready, 1'b0);
    step();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_result", out_result, 32'h0);
    release_rst();
    chk("in_ready_after_rst", in_ready, 1'b1);
    // single transfer, one-cycle latency
    out_ready = 1;
    rand_fields(); in_result = 32'h0000_00A5; in_rd = 5'd3; in_valid = 1;
    step();
    in_valid = 0;
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_result", out_result, 32'hA5);
    chk("lat_rd", out_rd, 5'd3);
    step();
    // back-to-back with stalled consumer
    out_ready = 0;
    send(32'd1);
    send(32'd2);
    chk("full_in_ready", in_ready, 1'b0);
    rand_fields(); in_result = 32'd3; in_valid = 1;
    step();
    out_ready = 1;
    begin
      int i;
      for (i = 0; i < 10 && !in_ready; i++) step();
      chk("third_accept_timeout", i < 10, 1'b1);
    end
    step();
    in_valid = 0;
    repeat (4) step();
    chk("drain_empty", q.size(), 0);
    // branch resolution
    rand_fields(); in_branch = 1; in_funct3 = 3'b100; {in_n, in_v} = 2'b10; in_valid = 1;
    step();
    in_valid = 0;
    chk("blt_taken", out_pc_src, BR_EN);
    step();
    rand_fields(); in_branch = 1; in_funct3 = 3'b100; {in_n, in_v} = 2'b11; in_valid = 1;
    step();
    in_valid = 0;
    chk("blt_not_taken", out_pc_src, 1'b0);
    step();
    rand_fields(); in_branch = 1; in_funct3 = 3'b111; in_c = 0; in_valid = 1;
    step();
    in_valid = 0;
    chk("bgeu_not_taken", out_pc_src, 1'b0);
    step();
    // flush while full
    out_ready = 0;
    send(32'h11);
    send(32'h22);
    rand_fields(); in_result = 32'hDEAD_BEEF; in_valid = 1; flush = 1;
    step();
    flush = 0; in_valid = 0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    out_ready = 1;
    repeat (3) step();
    // async reset while full and stalled
    out_ready = 0;
    send(32'h33);
    send(32'h44);
    #2 rst = 0;
    #1;
    q.delete();
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b0);
    chk("arst_out_result", out_result, 32'h0);
    chk("arst_out_rd", out_rd, 5'd0);
    release_rst();
    out_ready = 1;
    repeat (3) step();
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rand_fields();
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 99) < 3;
      step();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (4) step();
    chk("final_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
